rx_serial_7e2: RTL and testbench

RX_SERIAL_7E2 -- requirements
Module: rx_serial_7e2

---
 rtl/rx_serial_7e2.sv | 148 ++++++++++++++
 tb/tb_rx_serial_7e2.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_7e2.sv
// Asynchronous serial receiver for 7E2 frames (start, 7 data LSB first, even parity, 2 stops).
// Mid-bit sampling is timed from the first synchronized low seen while idle.
module rx_serial_7e2 #(
    parameter int unsigned M = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    input  logic       le_dado,
    output logic [6:0] dado_recebido,
    output logic       paridade_ok,
    output logic       erro_frame,
    output logic       overrun,
    output logic       tem_dado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP1    = 4'd4,
        STOP2    = 4'd5
    } estado_t;

    // The low-detect cycle is cycle 0 and the counter restarts one cycle later,
    // so the start-bit sample lands on counter value floor(M/2)-1.
    localparam logic [15:0] MEIO_M1 = 16'(M / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(M - 1);

    logic        sync_a;
    logic        sync_b;
    estado_t     estado;
    logic [15:0] contador;
    logic [2:0]  indice;
    logic [6:0]  dados;
    logic        par_bit;
    logic        stop1_bit;
    logic        amostra;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= entrada_serial;
            sync_b <= sync_a;
        end
    end

    always_comb begin
        amostra = 1'b0;
        if (estado == START)
            amostra = (contador == MEIO_M1);
        else
            amostra = (contador == BIT_M1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= INICIAL;
            contador      <= '0;
            indice        <= '0;
            dados         <= '0;
            par_bit       <= 1'b0;
            stop1_bit     <= 1'b0;
            dado_recebido <= '0;
            paridade_ok   <= 1'b0;
            erro_frame    <= 1'b0;
            overrun       <= 1'b0;
            tem_dado      <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (le_dado && tem_dado) begin
                tem_dado <= 1'b0;
                overrun  <= 1'b0;
            end
            case (estado)
                INICIAL: begin
                    contador <= '0;
                    indice   <= '0;
                    if (!sync_b)
                        estado <= START;
                end
                START: begin
                    if (amostra) begin
                        contador <= '0;
                        estado   <= sync_b ? INICIAL : DADOS;
                    end else begin
                        contador <= contador + 16'd1;
                    end
                end
                DADOS: begin
                    if (amostra) begin
                        contador <= '0;
                        dados    <= {sync_b, dados[6:1]};
                        indice   <= indice + 3'd1;
                        if (indice == 3'd6)
                            estado <= PARIDADE;
                    end else begin
                        contador <= contador + 16'd1;
                    end
                end
                PARIDADE: begin
                    if (amostra) begin
                        contador <= '0;
                        par_bit  <= sync_b;
                        estado   <= STOP1;
                    end else begin
                        contador <= contador + 16'd1;
                    end
                end
                STOP1: begin
                    if (amostra) begin
                        contador  <= '0;
                        stop1_bit <= sync_b;
                        estado    <= STOP2;
                    end else begin
                        contador <= contador + 16'd1;
                    end
                end
                STOP2: begin
                    if (amostra) begin
                        contador      <= '0;
                        estado        <= INICIAL;
                        dado_recebido <= dados;
                        paridade_ok   <= ~(^dados ^ par_bit);
                        erro_frame    <= ~stop1_bit | ~sync_b;
                        pronto        <= 1'b1;
                        // Completion wins over a simultaneous acknowledge.
                        tem_dado      <= 1'b1;
                        if (tem_dado && !le_dado)
                            overrun <= 1'b1;
                    end else begin
                        contador <= contador + 16'd1;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_rx_serial_7e2.sv
// Self-checking bench for rx_serial_7e2: directed 7E2 cases plus random frames,
// compared cycle by cycle against a frame-level reference model.
module tb_rx_serial_7e2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, line, le, sel;
    logic line_a, line_b, le_a, le_b;

    logic [6:0] dado_a, dado_b, obs_dado;
    logic par_a, par_b, obs_par, err_a, err_b, obs_err;
    logic ovr_a, ovr_b, obs_ovr, tem_a, tem_b, obs_tem;
    logic pr_a, pr_b, obs_pr;
    logic [3:0] est_a, est_b, obs_est;

    assign line_a = sel ? 1'b1 : line;
    assign line_b = sel ? line : 1'b1;
    assign le_a   = sel ? 1'b0 : le;
    assign le_b   = sel ? le : 1'b0;

    assign obs_dado = sel ? dado_b : dado_a;
    assign obs_par  = sel ? par_b  : par_a;
    assign obs_err  = sel ? err_b  : err_a;
    assign obs_ovr  = sel ? ovr_b  : ovr_a;
    assign obs_tem  = sel ? tem_b  : tem_a;
    assign obs_pr   = sel ? pr_b   : pr_a;
    assign obs_est  = sel ? est_b  : est_a;

    rx_serial_7e2 #(.M(8)) dut_a (
        .clock(clock), .reset(reset), .entrada_serial(line_a), .le_dado(le_a),
        .dado_recebido(dado_a), .paridade_ok(par_a), .erro_frame(err_a),
        .overrun(ovr_a), .tem_dado(tem_a), .pronto(pr_a), .db_estado(est_a)
    );

    rx_serial_7e2 #(.M(434)) dut_b (
        .clock(clock), .reset(reset), .entrada_serial(line_b), .le_dado(le_b),
        .dado_recebido(dado_b), .paridade_ok(par_b), .erro_frame(err_b),
        .overrun(ovr_b), .tem_dado(tem_b), .pronto(pr_b), .db_estado(est_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cur_m = 8;

    logic [6:0] m_dado = '0;
    logic m_par = 1'b0, m_err = 1'b0, m_tem = 1'b0, m_ovr = 1'b0;
    logic [6:0] nx_dado = '0;
    logic nx_par = 1'b0, nx_err = 1'b0;
    int exp_cyc = -1;
    int f_s = 0;
    int f_kind = 0;
    bit f_bad2 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected state code in synchronized cycle c of the current line event.
    function automatic int exp_state(input int c, input int kind, input bit bad2, input int m);
        int h;
        int k;
        int c2;
        h = m / 2;
        if (kind == 0 || c <= 0) return 0;
        if (c <= h) return 1;
        if (kind == 2) return 0;
        k = (c - h - 1) / m;
        if (k < 7) return 2;
        if (k == 7) return 3;
        if (k == 8) return 4;
        if (k == 9) return 5;
        if (bad2) begin
            c2 = c - (h + 10 * m + 1);
            return (c2 >= 1 && c2 <= h) ? 1 : 0;
        end
        return 0;
    endfunction

    task automatic step();
        bit exp_p;
        @(posedge clock);
        #1;
        cyc++;
        exp_p = 1'b0;
        if (cyc == exp_cyc) begin
            exp_p = 1'b1;
            if (m_tem && !le) m_ovr = 1'b1;
            else if (m_tem && le) m_ovr = 1'b0;
            m_tem  = 1'b1;
            m_dado = nx_dado;
            m_par  = nx_par;
            m_err  = nx_err;
        end else if (le && m_tem) begin
            m_tem = 1'b0;
            m_ovr = 1'b0;
        end
        check("pronto", obs_pr, exp_p);
        check("dado_recebido", obs_dado, m_dado);
        check("paridade_ok", obs_par, m_par);
        check("erro_frame", obs_err, m_err);
        check("tem_dado", obs_tem, m_tem);
        check("overrun", obs_ovr, m_ovr);
        check("db_estado", obs_est, exp_state(cyc - f_s - 2, f_kind, f_bad2, cur_m));
    endtask

    task automatic drive_le(input int mode);
        if (mode == 1)      le = (cyc + 1 == exp_cyc);
        else if (mode == 2) le = ($urandom_range(0, 7) == 0);
        else                le = 1'b0;
    endtask

    task automatic idle(input int n, input int mode);
        line = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive_le(mode);
            step();
        end
        le = 1'b0;
    endtask

    task automatic ack();
        le = 1'b1;
        step();
        le = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        line = 1'b1;
        le = 1'b0;
        m_dado = '0; m_par = 1'b0; m_err = 1'b0; m_tem = 1'b0; m_ovr = 1'b0;
        exp_cyc = -1;
        f_kind = 0;
        repeat (3) step();
        reset = 1'b1;
        idle(2 * cur_m, 0);
    endtask

    task automatic glitch(input int g);
        f_s = cyc;
        f_kind = 2;
        f_bad2 = 1'b0;
        line = 1'b0;
        repeat (g) step();
        idle(cur_m + 4, 0);
    endtask

    task automatic send_frame(input logic [6:0] d, input bit par_bad, input bit s1, input bit s2,
                              input int mode, input int abort_bit, input int gap);
        logic [10:0] bits;
        bits = {s2, s1, (^d) ^ par_bad, d, 1'b0};
        f_s     = cyc;
        f_kind  = 1;
        f_bad2  = !s2;
        exp_cyc = cyc + 3 + cur_m / 2 + 10 * cur_m;
        nx_dado = d;
        nx_par  = ((^d) ^ bits[8]) == 1'b0;
        nx_err  = !s1 || !s2;
        for (int b = 0; b < 11; b++) begin
            if (b == abort_bit) begin
                do_reset();
                return;
            end
            line = bits[b];
            for (int k = 0; k < cur_m; k++) begin
                drive_le(mode);
                step();
            end
        end
        le = 1'b0;
        idle(s2 ? gap : 2 * cur_m + gap, mode);
    endtask

    initial begin
        logic [6:0] d;
        bit pb, s1, s2;
        reset = 1'b0;
        line = 1'b1;
        le = 1'b0;
        sel = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        idle(4, 0);

        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 0, -1, 4);
        ack();
        idle(3, 0);
        send_frame(7'h41, 1'b1, 1'b1, 1'b1, 0, -1, 4);
        ack();
        send_frame(7'h41, 1'b0, 1'b0, 1'b1, 0, -1, 4);
        ack();
        glitch(2);

        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 0, -1, 0);
        send_frame(7'h35, 1'b0, 1'b1, 1'b1, 0, -1, 3);
        ack();
        idle(2, 0);

        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 0, -1, 0);
        send_frame(7'h35, 1'b0, 1'b1, 1'b1, 1, -1, 3);
        ack();

        send_frame(7'h55, 1'b0, 1'b1, 1'b1, 0, 4, 0);
        send_frame(7'h2A, 1'b0, 1'b1, 1'b1, 0, -1, 4);
        ack();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0)
                glitch($urandom_range(1, cur_m / 2));
            d  = 7'($urandom);
            pb = ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 7) != 0);
            s2 = ($urandom_range(0, 7) != 0);
            send_frame(d, pb, s1, s2, 2, -1, $urandom_range(0, 3));
        end
        idle(4, 2);

        sel = 1'b1;
        cur_m = 434;
        do_reset();
        send_frame(7'h41, 1'b0, 1'b1, 1'b1, 0, -1, 4);
        ack();
        idle(2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
